// File: rtl/torture_mem_pkg.sv
// Shared types and constants for the torture_mem randomized-latency memory.
// FSM states, out-of-range read pattern and xorshift32 step.
package torture_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [31:0] OOB_DATA = 32'hDEADBEEF;

  localparam int XS_A = 13;
  localparam int XS_B = 17;
  localparam int XS_C = 5;

  function automatic logic [31:0] xs_next(
    input logic [31:0] x
  );
    logic [31:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction

endpackage

// File: rtl/torture_xorshift32.sv
// Free-running xorshift32 generator; holds SEED while resetn is low.
// Drives the random grant decision of torture_mem.
module torture_xorshift32
  import torture_mem_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd314159265
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] state
);

  logic [31:0] state_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SEED;
    end else begin
      state_q <= xs_next(state_q);
    end
  end

  assign state = state_q;

endmodule

// File: rtl/torture_mem.sv
// Randomized-latency memory model for a picorv32-style native bus.
// Optional look-ahead fast path: define TORTURE_MEM_LOOKAHEAD_EN.
module torture_mem
  import torture_mem_pkg::*;
#(
  parameter int          ADDR_WORDS     = 4096,
  parameter logic [31:0] SEED           = 32'd314159265,
  parameter int          GRANT_BITS     = 1,
  parameter int          MAX_WAIT       = 8,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        trap,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        mem_la_read,
  input  logic        mem_la_write,
  input  logic [31:0] mem_la_addr,
  input  logic [31:0] mem_la_wdata,
  input  logic [3:0]  mem_la_wstrb,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] stall_count,
  output logic        err_oob,
  output logic        timeout
);

  localparam int AW =
    (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;
  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [31:0] GMASK =
    (32'd1 << GRANT_BITS) - 32'd1;
  localparam logic [31:0] TMO =
    32'(TIMEOUT_CYCLES);

  if (SEED == 32'd0) begin : g_bad_seed
    $error("torture_mem: SEED must be nonzero");
  end
  if (GRANT_BITS < 0 || GRANT_BITS > 8) begin : g_bad_gb
    $error("torture_mem: GRANT_BITS out of 0..8");
  end

  logic [31:0] x32;

  torture_xorshift32 #(
    .SEED(SEED)
  ) u_xs (
    .clk   (clk),
    .resetn(resetn),
    .state (x32)
  );

  state_e        state_q;
  logic [WW-1:0] wait_cnt_q;
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_cnt_q;
  logic [31:0]   wr_cnt_q;
  logic [31:0]   stall_q;
  logic [31:0]   cyc_q;
  logic          err_q;
  logic          tmo_q;

  // Power-up contents are zero; reset never touches the array.
  logic [31:0] mem_q [ADDR_WORDS] = '{default: '0};

  logic          grant;
  logic          forced;
  logic          acc_go;
  logic          acc_wr;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_wstrb;
  logic [29:0]   acc_idx;
  logic          acc_oob;
  logic [AW-1:0] acc_ptr;
  logic          mem_we;
  logic [31:0]   cyc_nx;

  assign grant  = (x32 & GMASK) == GMASK;
  assign forced = wait_cnt_q == WW'(MAX_WAIT);

  always_comb begin
    acc_go    = 1'b0;
    acc_wr    = |mem_wstrb;
    acc_addr  = mem_addr;
    acc_wdata = mem_wdata;
    acc_wstrb = mem_wstrb;
    if (state_q == S_WAIT) begin
      acc_go = grant || forced;
    end
`ifdef TORTURE_MEM_LOOKAHEAD_EN
    else if (state_q == S_IDLE && !trap && grant &&
             (mem_la_read || mem_la_write)) begin
      acc_go   = 1'b1;
      acc_addr = mem_la_addr;
      if (mem_la_read) begin
        acc_wr    = 1'b0;
        acc_wstrb = 4'h0;
      end else begin
        acc_wr    = 1'b1;
        acc_wdata = mem_la_wdata;
        acc_wstrb = mem_la_wstrb;
      end
    end
`endif
  end

  assign acc_idx = acc_addr[31:2];
  assign acc_oob = {2'b00, acc_idx} >= 32'(ADDR_WORDS);
  assign acc_ptr = acc_idx[AW-1:0];
  assign mem_we  = resetn && acc_go && acc_wr && !acc_oob;
  assign cyc_nx  = (cyc_q == TMO) ? cyc_q : cyc_q + 32'd1;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem_q[acc_ptr][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      stall_q    <= '0;
      cyc_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      cyc_q   <= cyc_nx;
      ready_q <= 1'b0;
      rdata_q <= '0;
      if (cyc_nx == TMO && !trap) begin
        tmo_q <= 1'b1;
      end
      if (acc_go) begin
        state_q <= S_RESP;
        ready_q <= 1'b1;
        if (acc_oob) begin
          err_q <= 1'b1;
        end
        if (acc_wr) begin
          wr_cnt_q <= wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_q <= rd_cnt_q + 32'd1;
          rdata_q  <= acc_oob ? OOB_DATA
                              : mem_q[acc_ptr];
        end
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (mem_valid && !ready_q && !trap) begin
              state_q <= S_WAIT;
            end
          end
          S_WAIT: begin
            wait_cnt_q <= wait_cnt_q + WW'(1);
            stall_q    <= stall_q + 32'd1;
          end
          S_RESP: begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  logic unused_in;
  assign unused_in = ^{mem_instr, acc_addr[1:0],
                       mem_la_read, mem_la_write,
                       mem_la_addr, mem_la_wdata,
                       mem_la_wstrb};

  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = stall_q;
  assign err_oob     = err_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_torture_mem.sv
// Bench for torture_mem: u_a always grants, u_b grants rarely.
// Expected read data queued per transaction, checked on mem_ready.
module tb_torture_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn     [2];
  logic        trap     [2];
  logic        mvalid   [2];
  logic        minstr   [2];
  logic [31:0] maddr    [2];
  logic [31:0] mwdata   [2];
  logic [3:0]  mwstrb   [2];
  logic        la_rd    [2];
  logic        la_wr    [2];
  logic [31:0] la_addr  [2];
  logic [31:0] la_wdata [2];
  logic [3:0]  la_wstrb [2];
  logic        rdy      [2];
  logic [31:0] rdata    [2];
  logic [31:0] rdc      [2];
  logic [31:0] wrc      [2];
  logic [31:0] stl      [2];
  logic        oob      [2];
  logic        tmo      [2];

  torture_mem #(
    .GRANT_BITS    (0),
    .TIMEOUT_CYCLES(50)
  ) u_a (
    .clk         (clk),
    .resetn      (rstn[0]),
    .trap        (trap[0]),
    .mem_valid   (mvalid[0]),
    .mem_instr   (minstr[0]),
    .mem_addr    (maddr[0]),
    .mem_wdata   (mwdata[0]),
    .mem_wstrb   (mwstrb[0]),
    .mem_ready   (rdy[0]),
    .mem_rdata   (rdata[0]),
    .mem_la_read (la_rd[0]),
    .mem_la_write(la_wr[0]),
    .mem_la_addr (la_addr[0]),
    .mem_la_wdata(la_wdata[0]),
    .mem_la_wstrb(la_wstrb[0]),
    .rd_count    (rdc[0]),
    .wr_count    (wrc[0]),
    .stall_count (stl[0]),
    .err_oob     (oob[0]),
    .timeout     (tmo[0])
  );

  torture_mem #(
    .GRANT_BITS(8),
    .MAX_WAIT  (3)
  ) u_b (
    .clk         (clk),
    .resetn      (rstn[1]),
    .trap        (trap[1]),
    .mem_valid   (mvalid[1]),
    .mem_instr   (minstr[1]),
    .mem_addr    (maddr[1]),
    .mem_wdata   (mwdata[1]),
    .mem_wstrb   (mwstrb[1]),
    .mem_ready   (rdy[1]),
    .mem_rdata   (rdata[1]),
    .mem_la_read (la_rd[1]),
    .mem_la_write(la_wr[1]),
    .mem_la_addr (la_addr[1]),
    .mem_la_wdata(la_wdata[1]),
    .mem_la_wstrb(la_wstrb[1]),
    .rd_count    (rdc[1]),
    .wr_count    (wrc[1]),
    .stall_count (stl[1]),
    .err_oob     (oob[1]),
    .timeout     (tmo[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        chk;
    logic [31:0] d;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  function automatic void sb_push(int i, exp_t e);
    if (i == 0) qa.push_back(e);
    else qb.push_back(e);
  endfunction

  function automatic int sb_size(int i);
    return (i == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t sb_pop(int i);
    if (i == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  function automatic void sb_clear(int i);
    if (i == 0) qa.delete();
    else qb.delete();
  endfunction

  logic prev_rdy [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (rdy[i]) begin
        chk($sformatf("ready_pulse[%0d]", i),
            32'(prev_rdy[i]), 32'd0);
        if (sb_size(i) == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready[%0d]: got 1 want 0",
                   i);
        end else begin
          e = sb_pop(i);
          if (e.chk)
            chk($sformatf("rdata[%0d]", i), rdata[i], e.d);
        end
      end else begin
        chk($sformatf("rdata_idle[%0d]", i),
            rdata[i], 32'd0);
      end
      prev_rdy[i] = rdy[i];
    end
  end

  task automatic txn(input int i,
                     input logic [31:0] ad,
                     input logic [31:0] wd,
                     input logic [3:0] st,
                     input logic [31:0] exp,
                     input int max_lat,
                     output int lat);
    exp_t e;
    e.chk = (st == 4'h0);
    e.d   = exp;
    sb_push(i, e);
    @(negedge clk);
    mvalid[i] = 1'b1;
    maddr[i]  = ad;
    mwdata[i] = wd;
    mwstrb[i] = st;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rdy[i] && lat < max_lat + 8);
    if (!rdy[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_wait[%0d]: got 0 want 1", i);
      sb_clear(i);
    end
    @(negedge clk);
    mvalid[i] = 1'b0;
    mwstrb[i] = 4'h0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[13];

  initial begin
    int lat;
    int erd;
    int ewr;
    logic eoob;
    logic [31:0] s0;
    logic [31:0] r0;
    logic [31:0] bm [16];
    int brd;
    int bwr;

    vt[0]  = '{32'h10,       32'h11223344, 4'hF, 32'h0};
    vt[1]  = '{32'h10,       32'h0,        4'h0, 32'h11223344};
    vt[2]  = '{32'h20,       32'hAABBCCDD, 4'h5, 32'h0};
    vt[3]  = '{32'h20,       32'h0,        4'h0, 32'h00BB00DD};
    vt[4]  = '{32'h24,       32'hFFFFFFFF, 4'h8, 32'h0};
    vt[5]  = '{32'h24,       32'h0,        4'h0, 32'hFF000000};
    vt[6]  = '{32'h4000,     32'h0,        4'h0, 32'hDEADBEEF};
    vt[7]  = '{32'h4000,     32'h12345678, 4'hF, 32'h0};
    vt[8]  = '{32'h0,        32'h0,        4'h0, 32'h0};
    vt[9]  = '{32'h3FFC,     32'hCAFEF00D, 4'hF, 32'h0};
    vt[10] = '{32'h3FFC,     32'h0,        4'h0, 32'hCAFEF00D};
    vt[11] = '{32'h10,       32'h0,        4'h0, 32'h11223344};
    vt[12] = '{32'h80000010, 32'h0,        4'h0, 32'hDEADBEEF};

    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0;     trap[i] = 1'b0;
      mvalid[i] = 1'b0;   minstr[i] = 1'b0;
      maddr[i] = '0;      mwdata[i] = '0;
      mwstrb[i] = '0;     la_rd[i] = 1'b0;
      la_wr[i] = 1'b0;    la_addr[i] = '0;
      la_wdata[i] = '0;   la_wstrb[i] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(rdy[i]), 32'd0);
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_rdc", rdc[i], 32'd0);
      chk("rst_wrc", wrc[i], 32'd0);
      chk("rst_stall", stl[i], 32'd0);
      chk("rst_oob", 32'(oob[i]), 32'd0);
      chk("rst_tmo", 32'(tmo[i]), 32'd0);
    end

    @(negedge clk);
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    repeat (49) @(posedge clk);
    #1;
    chk("tmo_49", 32'(tmo[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("tmo_50", 32'(tmo[0]), 32'd1);
    chk("tmo_b_50", 32'(tmo[1]), 32'd0);

    erd = 0;
    ewr = 0;
    eoob = 1'b0;
    for (int k = 0; k < 13; k++) begin
      txn(0, vt[k].addr, vt[k].wdata, vt[k].wstrb,
          vt[k].rdata, 2, lat);
      if (vt[k].wstrb == 4'h0) erd++;
      else ewr++;
      if (vt[k].addr[31:2] >= 30'd4096) eoob = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("lat_a[%0d]", k), 32'(lat), 32'd2);
      chk($sformatf("rdc_a[%0d]", k), rdc[0], 32'(erd));
      chk($sformatf("wrc_a[%0d]", k), wrc[0], 32'(ewr));
      chk($sformatf("oob_a[%0d]", k), 32'(oob[0]),
          32'(eoob));
      chk($sformatf("stall_a[%0d]", k), stl[0], 32'd0);
    end

    @(negedge clk);
    trap[0]   = 1'b1;
    mvalid[0] = 1'b1;
    maddr[0]  = 32'h10;
    mwstrb[0] = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    chk("trap_block_rdc", rdc[0], 32'(erd));
    chk("trap_block_rdy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    mvalid[0] = 1'b0;
    trap[0]   = 1'b0;

    sb_push(0, '{1'b1, 32'h00BB00DD});
    @(negedge clk);
    mvalid[0] = 1'b1;
    maddr[0]  = 32'h20;
    @(posedge clk);
    @(negedge clk);
    trap[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("trap_wait_rdy", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    mvalid[0] = 1'b0;
    trap[0]   = 1'b0;
    erd++;
    chk("trap_wait_rdc", rdc[0], 32'(erd));

    @(negedge clk);
    mvalid[0] = 1'b1;
    maddr[0]  = 32'h30;
    mwdata[0] = 32'h55AA55AA;
    mwstrb[0] = 4'hF;
    @(posedge clk);
    #1;
    rstn[0] = 1'b0;
    #1;
    chk("rstw_rdy", 32'(rdy[0]), 32'd0);
    chk("rstw_wrc", wrc[0], 32'd0);
    chk("rstw_rdc", rdc[0], 32'd0);
    chk("rstw_stall", stl[0], 32'd0);
    chk("rstw_oob", 32'(oob[0]), 32'd0);
    chk("rstw_tmo", 32'(tmo[0]), 32'd0);
    @(negedge clk);
    mvalid[0] = 1'b0;
    mwstrb[0] = 4'h0;
    @(negedge clk);
    rstn[0] = 1'b1;
    txn(0, 32'h30, 32'h0, 4'h0, 32'h0, 2, lat);
    chk("rstw_lat", 32'(lat), 32'd2);
    txn(0, 32'h10, 32'h0, 4'h0, 32'h11223344, 2, lat);
    erd = 2;
    @(posedge clk);
    #1;
    chk("rstw_keep_rdc", rdc[0], 32'(erd));
    chk("rstw_keep_wrc", wrc[0], 32'd0);

`ifdef TORTURE_MEM_LOOKAHEAD_EN
    sb_push(0, '{1'b1, 32'h11223344});
    @(negedge clk);
    la_rd[0]   = 1'b1;
    la_addr[0] = 32'h10;
    @(posedge clk);
    #1;
    chk("la_ready", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    la_rd[0] = 1'b0;
    erd++;
    chk("la_rdc", rdc[0], 32'(erd));
`else
    @(negedge clk);
    la_rd[0]   = 1'b1;
    la_addr[0] = 32'h10;
    repeat (3) @(posedge clk);
    #1;
    chk("la_off_rdy", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    la_rd[0] = 1'b0;
    chk("la_off_rdc", rdc[0], 32'(erd));
`endif

    for (int k = 0; k < 16; k++) bm[k] = 32'h0;
    brd = 0;
    bwr = 0;
    for (int n = 0; n < 24; n++) begin
      int k;
      logic [31:0] wd;
      logic [3:0] st;
      k = $urandom_range(0, 15);
      r0 = bm[k];
      if ((n % 3) != 2) begin
        wd = $urandom;
        st = 4'($urandom_range(1, 15));
        for (int b = 0; b < 4; b++)
          if (st[b]) bm[k][8*b +: 8] = wd[8*b +: 8];
        bwr++;
      end else begin
        wd = 32'h0;
        st = 4'h0;
        brd++;
      end
      s0 = stl[1];
      txn(1, 32'h100 + 32'(4 * k), wd, st, r0, 5, lat);
      @(posedge clk);
      #1;
      chk($sformatf("lat_b_le5[%0d]", n),
          32'(lat <= 5), 32'd1);
      chk($sformatf("stall_b_le3[%0d]", n),
          32'((stl[1] - s0) <= 32'd3), 32'd1);
      chk($sformatf("stall_b_lat[%0d]", n),
          stl[1] - s0, 32'(lat - 2));
    end
    chk("rdc_b", rdc[1], 32'(brd));
    chk("wrc_b", wrc[1], 32'(bwr));
    chk("oob_b", 32'(oob[1]), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty_a", 32'(qa.size()), 32'd0);
    chk("sb_empty_b", 32'(qb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/torture_mem.md
TORTURE_MEM -- requirements
Module: torture_mem

Interface
REQ-001 SHALL have parameter ADDR_WORDS, default 4096: memory depth in 32-bit words.
REQ-002 SHALL have parameter SEED, default 314159265: xorshift32 reset value; 0 is illegal, flagged by elaboration assertion.
REQ-003 SHALL have parameter GRANT_BITS, default 1 (range 0..8): grant when low GRANT_BITS of x32 are all ones; 0 means always grant.
REQ-004 SHALL have parameter MAX_WAIT, default 8: forced grant after MAX_WAIT consecutive denied wait cycles.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 100000.
REQ-006 SHALL have one clock; reset is asynchronous and active-low: ports clk and resetn.
REQ-007 Ports, in order: clk in 1 clock; resetn in 1 async active-low reset; trap in 1 core halted; mem_valid in 1; mem_instr in 1; mem_addr in 32; mem_wdata in 32; mem_wstrb in 4; mem_ready out 1; mem_rdata out 32; mem_la_read in 1; mem_la_write in 1; mem_la_addr in 32; mem_la_wdata in 32; mem_la_wstrb in 4; rd_count out 32; wr_count out 32; stall_count out 32; err_oob out 1 sticky out-of-range flag; timeout out 1 sticky.

Function
REQ-008 x32 SHALL advance every clk while resetn high: x^=x<<13; x^=x>>17; x^=x<<5.
REQ-009 FSM states SHALL be IDLE, WAIT, RESP.
REQ-010 IDLE: mem_valid && !mem_ready && !trap -> WAIT; otherwise stay.
REQ-011 WAIT: grant (random or wait_cnt==MAX_WAIT) -> perform access, go RESP; no grant -> wait_cnt+1, stall_count+1, stay.
REQ-012 Access: mem_wstrb==0 reads word mem_addr>>2 into mem_rdata; else byte lanes with set strobe bits written from mem_wdata.
REQ-013 RESP: mem_ready=1 for exactly one cycle with mem_rdata valid (reads); -> IDLE, wait_cnt cleared; minimum native latency 2 cycles valid-to-ready.
REQ-014 mem_rdata SHALL be 0 whenever mem_ready is 0.
REQ-015 Word index >= ADDR_WORDS: read returns 32'hDEADBEEF, write dropped, err_oob set; transaction still completes.
REQ-016 rd_count/wr_count SHALL increment on the RESP cycle of each read/write; all counters wrap at 2^32.
REQ-017 With trap high, no new transaction SHALL start; an access in WAIT SHALL complete normally.
REQ-018 timeout SHALL set when the free-running cycle counter reaches TIMEOUT_CYCLES while trap low; cycle counter saturates.
REQ-019 Memory contents SHALL be initialised to 0 and not cleared by reset.

Reset
REQ-020 resetn low SHALL asynchronously force: state IDLE, mem_ready 0, mem_rdata 0, x32 SEED, wait_cnt 0, all counters 0, err_oob 0, timeout 0.
REQ-021 Reset mid-WAIT SHALL abort the access with no memory write.

Configuration
REQ-022 Macro TORTURE_MEM_LOOKAHEAD_EN defined: in IDLE, mem_la_read or mem_la_write with grant SHALL perform the access on mem_la_addr/mem_la_wdata/mem_la_wstrb and go RESP (1-cycle latency); with no grant the native path of REQ-010 applies; la_read has priority over la_write.
REQ-023 Macro undefined: mem_la_* inputs SHALL be ignored; only native path.

Structure
REQ-024 Package torture_mem_pkg SHALL hold the FSM state enum, OOB_DATA = 32'hDEADBEEF and the xorshift shift constants 13/17/5.
REQ-025 Sub-module torture_xorshift32 (clk, resetn, SEED parameter, 32-bit state out) SHALL implement REQ-008.

Verification
REQ-026 GRANT_BITS=0, write 32'h11223344 strobe 4'hF to 0x10, read 0x10 -> ready 2 cycles after valid, rdata 32'h11223344, wr_count=1, rd_count=1.
REQ-027 Write 32'hAABBCCDD strobe 4'b0101 over 0 at 0x20, read -> 32'h00BB00DD.
REQ-028 GRANT_BITS=8, MAX_WAIT=3 -> every transaction ready within 3+2 cycles; stall_count increments by <=3 per transaction.
REQ-029 Read word 4096 (addr 0x4000) -> rdata 32'hDEADBEEF, err_oob=1 and stays 1; write there leaves word 0 unchanged.
REQ-030 LOOKAHEAD_EN, GRANT_BITS=0, mem_la_read 0x10 -> mem_ready next cycle with correct data; TIMEOUT_CYCLES=50, trap low -> timeout=1 at cycle 50.
REQ-031 resetn dropped during WAIT of write to 0x30 -> mem_ready 0 immediately, word 0x30 unchanged, counters 0.
